// File: rtl/id_ex_reg_if.sv
// ID/EX pipeline register bus: decode-side inputs, WB bypass inputs, execute-side outputs.
// slave = the pipeline register itself, master = whatever drives ID/WB and consumes EX.
interface id_ex_reg_if #(
  parameter int DATA_W    = 32,
  parameter int REG_AW    = 5,
  parameter int ALUCTRL_W = 3
);
  logic                 StallE;
  logic                 FlushE;

  logic [DATA_W-1:0]    RD1_in;
  logic [DATA_W-1:0]    RD2_in;
  logic [REG_AW-1:0]    RsD;
  logic [REG_AW-1:0]    RtD;
  logic [REG_AW-1:0]    RdD;
  logic [DATA_W-1:0]    SignImmD;
  logic [DATA_W-1:0]    PCPlus4D;
  logic                 RegWriteD;
  logic                 MemtoRegD;
  logic                 MemWriteD;
  logic                 ALUSrcD;
  logic                 RegDstD;
  logic [ALUCTRL_W-1:0] ALUControlD;
  logic                 ValidD;

  logic                 RegWriteW;
  logic [REG_AW-1:0]    WriteRegW;
  logic [DATA_W-1:0]    ResultW;

  logic [DATA_W-1:0]    RD1_out;
  logic [DATA_W-1:0]    RD2_out;
  logic [REG_AW-1:0]    RsE;
  logic [REG_AW-1:0]    RtE;
  logic [REG_AW-1:0]    RdE;
  logic [DATA_W-1:0]    SignImmE;
  logic [DATA_W-1:0]    PCPlus4E;
  logic                 RegWriteE;
  logic                 MemtoRegE;
  logic                 MemWriteE;
  logic                 ALUSrcE;
  logic                 RegDstE;
  logic [ALUCTRL_W-1:0] ALUControlE;
  logic                 ValidE;
  logic [31:0]          BubbleCnt;

  modport master (
    output StallE, FlushE,
    output RD1_in, RD2_in, RsD, RtD, RdD, SignImmD, PCPlus4D,
    output RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD, ALUControlD, ValidD,
    output RegWriteW, WriteRegW, ResultW,
    input  RD1_out, RD2_out, RsE, RtE, RdE, SignImmE, PCPlus4E,
    input  RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, ALUControlE, ValidE,
    input  BubbleCnt
  );

  modport slave (
    input  StallE, FlushE,
    input  RD1_in, RD2_in, RsD, RtD, RdD, SignImmD, PCPlus4D,
    input  RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD, ALUControlD, ValidD,
    input  RegWriteW, WriteRegW, ResultW,
    output RD1_out, RD2_out, RsE, RtE, RdE, SignImmE, PCPlus4E,
    output RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, ALUControlE, ValidE,
    output BubbleCnt
  );
endinterface

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with stall, flush and WB-to-operand bypass/refresh.
// Optional flush counter on BubbleCnt is built only when ID_EX_PERF_EN is defined.
module id_ex_reg #(
  parameter int DATA_W    = 32,
  parameter int REG_AW    = 5,
  parameter int ALUCTRL_W = 3
) (
  input  logic        clk,
  input  logic        rst,
  id_ex_reg_if.slave  bus
);

  logic [DATA_W-1:0]    r_rd1;
  logic [DATA_W-1:0]    r_rd2;
  logic [REG_AW-1:0]    r_rs;
  logic [REG_AW-1:0]    r_rt;
  logic [REG_AW-1:0]    r_rd;
  logic [DATA_W-1:0]    r_imm;
  logic [DATA_W-1:0]    r_pc4;
  logic                 r_regwrite;
  logic                 r_memtoreg;
  logic                 r_memwrite;
  logic                 r_alusrc;
  logic                 r_regdst;
  logic [ALUCTRL_W-1:0] r_aluctrl;
  logic                 r_valid;

  logic w_wb_live;
  logic w_byp_rs;
  logic w_byp_rt;
  logic w_ref_rs;
  logic w_ref_rt;

  // Register 0 is hardwired, so a WB "write" to it must never be forwarded.
  assign w_wb_live = bus.RegWriteW && (bus.WriteRegW != '0);
  assign w_byp_rs  = w_wb_live && (bus.WriteRegW == bus.RsD);
  assign w_byp_rt  = w_wb_live && (bus.WriteRegW == bus.RtD);
  assign w_ref_rs  = w_wb_live && (bus.WriteRegW == r_rs);
  assign w_ref_rt  = w_wb_live && (bus.WriteRegW == r_rt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd1      <= '0;
      r_rd2      <= '0;
      r_rs       <= '0;
      r_rt       <= '0;
      r_rd       <= '0;
      r_imm      <= '0;
      r_pc4      <= '0;
      r_regwrite <= 1'b0;
      r_memtoreg <= 1'b0;
      r_memwrite <= 1'b0;
      r_alusrc   <= 1'b0;
      r_regdst   <= 1'b0;
      r_aluctrl  <= '0;
      r_valid    <= 1'b0;
    end else if (bus.FlushE) begin
      r_rd1      <= '0;
      r_rd2      <= '0;
      r_rs       <= '0;
      r_rt       <= '0;
      r_rd       <= '0;
      r_imm      <= '0;
      r_pc4      <= '0;
      r_regwrite <= 1'b0;
      r_memtoreg <= 1'b0;
      r_memwrite <= 1'b0;
      r_alusrc   <= 1'b0;
      r_regdst   <= 1'b0;
      r_aluctrl  <= '0;
      r_valid    <= 1'b0;
    end else if (bus.StallE) begin
      // Held operands track WB writes so the stalled instruction sees fresh data.
      if (w_ref_rs) r_rd1 <= bus.ResultW;
      if (w_ref_rt) r_rd2 <= bus.ResultW;
    end else begin
      r_rd1      <= w_byp_rs ? bus.ResultW : bus.RD1_in;
      r_rd2      <= w_byp_rt ? bus.ResultW : bus.RD2_in;
      r_rs       <= bus.RsD;
      r_rt       <= bus.RtD;
      r_rd       <= bus.RdD;
      r_imm      <= bus.SignImmD;
      r_pc4      <= bus.PCPlus4D;
      r_regwrite <= bus.RegWriteD;
      r_memtoreg <= bus.MemtoRegD;
      r_memwrite <= bus.MemWriteD;
      r_alusrc   <= bus.ALUSrcD;
      r_regdst   <= bus.RegDstD;
      r_aluctrl  <= bus.ALUControlD;
      r_valid    <= bus.ValidD;
    end
  end

  assign bus.RD1_out     = r_rd1;
  assign bus.RD2_out     = r_rd2;
  assign bus.RsE         = r_rs;
  assign bus.RtE         = r_rt;
  assign bus.RdE         = r_rd;
  assign bus.SignImmE    = r_imm;
  assign bus.PCPlus4E    = r_pc4;
  assign bus.RegWriteE   = r_regwrite;
  assign bus.MemtoRegE   = r_memtoreg;
  assign bus.MemWriteE   = r_memwrite;
  assign bus.ALUSrcE     = r_alusrc;
  assign bus.RegDstE     = r_regdst;
  assign bus.ALUControlE = r_aluctrl;
  assign bus.ValidE      = r_valid;

`ifdef ID_EX_PERF_EN
  logic [31:0] r_bubble_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bubble_cnt <= '0;
    end else if (bus.FlushE && (r_bubble_cnt != '1)) begin
      r_bubble_cnt <= r_bubble_cnt + 32'd1;
    end
  end

  assign bus.BubbleCnt = r_bubble_cnt;
`else
  assign bus.BubbleCnt = '0;
`endif

endmodule

// File: tb/tb_id_ex_reg.sv
// Self-checking bench for id_ex_reg: directed scenarios plus randomized traffic
// against a field-level reference model of the E-stage contents.
module tb_id_ex_reg;

  typedef struct packed {
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [31:0] pc4;
    logic        rw;
    logic        m2r;
    logic        mw;
    logic        asrc;
    logic        rdst;
    logic [2:0]  aluc;
    logic        valid;
  } e_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;
  e_t   exp_e;
  longint exp_bcnt;

  id_ex_reg_if #(.DATA_W(32), .REG_AW(5), .ALUCTRL_W(3)) b();

  id_ex_reg #(.DATA_W(32), .REG_AW(5), .ALUCTRL_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (b.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1);
  end

  function automatic e_t get_e();
    return {b.RD1_out, b.RD2_out, b.RsE, b.RtE, b.RdE, b.SignImmE, b.PCPlus4E,
            b.RegWriteE, b.MemtoRegE, b.MemWriteE, b.ALUSrcE, b.RegDstE,
            b.ALUControlE, b.ValidE};
  endfunction

  function automatic logic [31:0] exp_bc();
`ifdef ID_EX_PERF_EN
    return exp_bcnt[31:0];
`else
    return 32'h0;
`endif
  endfunction

  function automatic bit wb_hits(logic [4:0] r);
    return b.RegWriteW && (r != 5'd0) && (b.WriteRegW == r);
  endfunction

  // Next E-stage contents from the current ones and the inputs on the bus.
  function automatic e_t ref_next(e_t c);
    e_t n = c;
    if (b.FlushE) begin
      n = '0;
    end else if (b.StallE) begin
      if (wb_hits(c.rs)) n.rd1 = b.ResultW;
      if (wb_hits(c.rt)) n.rd2 = b.ResultW;
    end else begin
      n.rd1   = wb_hits(b.RsD) ? b.ResultW : b.RD1_in;
      n.rd2   = wb_hits(b.RtD) ? b.ResultW : b.RD2_in;
      n.rs    = b.RsD;
      n.rt    = b.RtD;
      n.rd    = b.RdD;
      n.imm   = b.SignImmD;
      n.pc4   = b.PCPlus4D;
      n.rw    = b.RegWriteD;
      n.m2r   = b.MemtoRegD;
      n.mw    = b.MemWriteD;
      n.asrc  = b.ALUSrcD;
      n.rdst  = b.RegDstD;
      n.aluc  = b.ALUControlD;
      n.valid = b.ValidD;
    end
    return n;
  endfunction

  task automatic clear_inputs();
    b.StallE = 0; b.FlushE = 0;
    b.RD1_in = '0; b.RD2_in = '0; b.RsD = '0; b.RtD = '0; b.RdD = '0;
    b.SignImmD = '0; b.PCPlus4D = '0;
    b.RegWriteD = 0; b.MemtoRegD = 0; b.MemWriteD = 0; b.ALUSrcD = 0; b.RegDstD = 0;
    b.ALUControlD = '0; b.ValidD = 0;
    b.RegWriteW = 0; b.WriteRegW = '0; b.ResultW = '0;
  endtask

  task automatic rand_d();
    b.RD1_in = $urandom; b.RD2_in = $urandom;
    b.RsD = 5'($urandom); b.RtD = 5'($urandom); b.RdD = 5'($urandom);
    b.SignImmD = $urandom; b.PCPlus4D = $urandom;
    b.RegWriteD = 1'($urandom); b.MemtoRegD = 1'($urandom); b.MemWriteD = 1'($urandom);
    b.ALUSrcD = 1'($urandom); b.RegDstD = 1'($urandom);
    b.ALUControlD = 3'($urandom); b.ValidD = 1'($urandom);
  endtask

  // Called just after a negedge: advance the model, cross one posedge, return at the next negedge.
  task automatic step();
    exp_e = ref_next(exp_e);
    if (b.FlushE && exp_bcnt < 64'hFFFF_FFFF) exp_bcnt++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    n_checks++;
    if (get_e() !== '0) $display("FAIL reset_init: got %h required 0", get_e());
    else n_pass++;
    rand_d(); b.ValidD = 1; b.RegWriteD = 1; b.RD1_in = 32'hA5A5_0001;
    step();
    n_checks++;
    if (get_e() !== exp_e) $display("FAIL reset_preload: got %h required %h", get_e(), exp_e);
    else n_pass++;
    #2 rst = 1;
    #1;
    exp_e = '0; exp_bcnt = 0;
    n_checks++;
    if (get_e() !== '0) $display("FAIL reset_async: got %h required 0", get_e());
    else n_pass++;
    n_checks++;
    if (b.ValidE !== 1'b0) $display("FAIL reset_valid: got %b required 0", b.ValidE);
    else n_pass++;
    n_checks++;
    if (b.BubbleCnt !== 32'h0) $display("FAIL reset_bcnt: got %h required 0", b.BubbleCnt);
    else n_pass++;
    @(negedge clk);
    rst = 0;
    clear_inputs();
  endtask

  task automatic test_normal_load();
    clear_inputs();
    b.RD1_in = 32'h11; b.RD2_in = 32'h22; b.RsD = 5'd3; b.RtD = 5'd4;
    b.RegWriteD = 1; b.ALUControlD = 3'b010; b.ValidD = 1;
    step();
    n_checks++;
    if ({b.RD1_out, b.RD2_out, b.RsE, b.RtE, b.RegWriteE, b.ALUControlE}
        !== {32'h11, 32'h22, 5'd3, 5'd4, 1'b1, 3'b010})
      $display("FAIL load_fields: got %h/%h/%0d/%0d/%b/%b required 11/22/3/4/1/010",
               b.RD1_out, b.RD2_out, b.RsE, b.RtE, b.RegWriteE, b.ALUControlE);
    else n_pass++;
    n_checks++;
    if (get_e() !== exp_e) $display("FAIL load_all: got %h required %h", get_e(), exp_e);
    else n_pass++;
  endtask

  task automatic test_wb_bypass();
    clear_inputs();
    b.RsD = 5'd5; b.RD1_in = 32'hDEAD;
    b.RegWriteW = 1; b.WriteRegW = 5'd5; b.ResultW = 32'hBEEF;
    step();
    n_checks++;
    if (b.RD1_out !== 32'hBEEF) $display("FAIL bypass_rs: got %h required beef", b.RD1_out);
    else n_pass++;
    b.WriteRegW = 5'd0;
    step();
    n_checks++;
    if (b.RD1_out !== 32'hDEAD) $display("FAIL bypass_r0: got %h required dead", b.RD1_out);
    else n_pass++;
    clear_inputs();
    b.RtD = 5'd9; b.RD2_in = 32'h1234;
    b.RegWriteW = 1; b.WriteRegW = 5'd9; b.ResultW = 32'h5678;
    step();
    n_checks++;
    if (b.RD2_out !== 32'h5678) $display("FAIL bypass_rt: got %h required 5678", b.RD2_out);
    else n_pass++;
  endtask

  task automatic test_stall_refresh();
    e_t held;
    clear_inputs();
    rand_d();
    b.RsD = 5'd2; b.RtD = 5'd7; b.RD2_in = 32'h1; b.ValidD = 1;
    step();
    held = exp_e;
    b.StallE = 1;
    rand_d();
    step();
    n_checks++;
    if (get_e() !== held) $display("FAIL stall_hold1: got %h required %h", get_e(), held);
    else n_pass++;
    rand_d();
    b.RegWriteW = 1; b.WriteRegW = 5'd7; b.ResultW = 32'h99;
    step();
    held.rd2 = 32'h99;
    n_checks++;
    if (get_e() !== held) $display("FAIL stall_refresh: got %h required %h", get_e(), held);
    else n_pass++;
    n_checks++;
    if (b.RD2_out !== 32'h99) $display("FAIL stall_rd2: got %h required 99", b.RD2_out);
    else n_pass++;
    b.WriteRegW = 5'd0;
    step();
    n_checks++;
    if (get_e() !== held) $display("FAIL stall_r0: got %h required %h", get_e(), held);
    else n_pass++;
    clear_inputs();
  endtask

  task automatic test_flush_over_stall();
    clear_inputs();
    rand_d();
    b.ValidD = 1; b.RsD = 5'd1; b.RtD = 5'd1;
    step();
    rand_d();
    b.StallE = 1; b.FlushE = 1;
    b.RegWriteD = 1; b.MemWriteD = 1; b.ValidD = 1;
    b.RegWriteW = 1; b.WriteRegW = 5'd1; b.ResultW = 32'hFFFF_0000;
    step();
    n_checks++;
    if ({b.RegWriteE, b.MemWriteE, b.ValidE, b.RsE, b.RtE, b.RdE} !== '0)
      $display("FAIL flush_ctrl: got %b%b%b rs%0d rt%0d rd%0d required all 0",
               b.RegWriteE, b.MemWriteE, b.ValidE, b.RsE, b.RtE, b.RdE);
    else n_pass++;
    n_checks++;
    if (get_e() !== '0) $display("FAIL flush_all: got %h required 0", get_e());
    else n_pass++;
    clear_inputs();
  endtask

  task automatic test_perf_counter();
    @(negedge clk);
    #2 rst = 1;
    #1 exp_e = '0; exp_bcnt = 0;
    @(negedge clk);
    rst = 0;
    clear_inputs();
    b.FlushE = 1;
    repeat (3) step();
    b.FlushE = 0;
    step();
    n_checks++;
    if (b.BubbleCnt !== exp_bc()) $display("FAIL bcnt_three: got %h required %h", b.BubbleCnt, exp_bc());
    else n_pass++;
`ifdef ID_EX_PERF_EN
    n_checks++;
    if (b.BubbleCnt !== 32'd3) $display("FAIL bcnt_lit3: got %h required 3", b.BubbleCnt);
    else n_pass++;
    force dut.r_bubble_cnt = 32'hFFFF_FFFE;
    #1 release dut.r_bubble_cnt;
    exp_bcnt = 64'hFFFF_FFFE;
    b.FlushE = 1;
    repeat (3) step();
    b.FlushE = 0;
    n_checks++;
    if (b.BubbleCnt !== 32'hFFFF_FFFF) $display("FAIL bcnt_sat: got %h required ffffffff", b.BubbleCnt);
    else n_pass++;
`else
    b.FlushE = 1;
    repeat (3) step();
    b.FlushE = 0;
    n_checks++;
    if (b.BubbleCnt !== 32'h0) $display("FAIL bcnt_off: got %h required 0", b.BubbleCnt);
    else n_pass++;
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      rand_d();
      b.FlushE    = ($urandom_range(0, 7) == 0);
      b.StallE    = ($urandom_range(0, 3) == 0);
      b.RegWriteW = 1'($urandom);
      b.ResultW   = $urandom;
      case ($urandom_range(0, 5))
        0:       b.WriteRegW = b.RsD;
        1:       b.WriteRegW = b.RtD;
        2:       b.WriteRegW = exp_e.rs;
        3:       b.WriteRegW = exp_e.rt;
        4:       b.WriteRegW = 5'd0;
        default: b.WriteRegW = 5'($urandom);
      endcase
      step();
      n_checks++;
      if (get_e() !== exp_e) $display("FAIL random_%0d: got %h required %h", i, get_e(), exp_e);
      else n_pass++;
      if (i % 50 == 49) begin
        n_checks++;
        if (b.BubbleCnt !== exp_bc()) $display("FAIL random_bcnt_%0d: got %h required %h", i, b.BubbleCnt, exp_bc());
        else n_pass++;
      end
    end
    clear_inputs();
  endtask

  initial begin
    rst = 1;
    exp_e = '0;
    exp_bcnt = 0;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst = 0;
    test_reset();
    test_normal_load();
    test_wb_bypass();
    test_stall_refresh();
    test_flush_over_stall();
    test_perf_counter();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
